chacha_core: RTL and testbench
==============================

// Module: chacha_core
// PURPOSE
//  Round scheduler and feed-forward stage around four chacha_qr4 instances, one per column/diagonal lane.
//  Accepts a 16-word ChaCha state, alternates column and diagonal half-rounds through the qr4 pipelines.
//  Adds the input state (feed-forward) and emits the 512-bit keystream block to the mem_hash consumers.
//  One block in flight at a time; upstream/downstream use valid/ready.
// PARAMETERS
//  ROUNDS   4   double rounds (column+diagonal); 4 = ChaCha8, 10 = ChaCha20; legal 1..15
// PORTS
//  clk        in   1    clock, all logic on posedge
//  rst        in   1    synchronous reset, active-high
//  in_valid   in   1    in_state valid
//  in_ready   out  1    core can accept a block (high only in IDLE)
//  in_state   in   512  word i at [32*i+31:32*i], i=0..15
//  out_valid  out  1    out_state valid, held until out_ready
//  out_ready  in   1    consumer accepts out_state
//  out_state  out  512  result block, same packing as in_state
//  busy       out  1    state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, out_state=0, busy=0, phase=0, half=0; init/work regs don't-care.
//  Reset mid-block aborts it; qr4 pipeline contents ignored (capture only in RUN).
//  FSM: IDLE -> RUN on in_valid&in_ready (edge E0: init<=in_state, work<=in_state, phase=0, half=0).
//  RUN: phase counts 0..4. qr4 clk_en tied 1; qr4 inputs = lane words of work per half parity.
//   Even half = columns: lane k = (k, 4+k, 8+k, 12+k), k=0..3.
//   Odd half = diagonals: (0,5,10,15) (1,6,11,12) (2,7,8,13) (3,4,9,14).
//   Inputs sampled by qr4 at phase-0 edge; outputs valid 4 edges later.
//   Phase-4 edge: work words <= qr4 a/b/c/d outputs, scattered back to the same indices; half++.
//   Half-round = 5 cycles. After half == 2*ROUNDS-1 captures -> ADD.
//  ADD (one cycle): out_state[i] <= work[i] + init[i] mod 2^32 per word; out_valid<=1; -> DONE.
//  DONE: out_valid=1, out_state stable; out_valid&out_ready -> IDLE (out_valid=0).
//   No accept in the same cycle as the output handshake.
//  Latency: accept edge E0 to out_valid high = 10*ROUNDS+1 edges (ROUNDS=4: 41).
//   Min block period = 10*ROUNDS+3 cycles.
//  in_valid while busy is ignored; in_state is sampled only at E0.
//  out_ready while not out_valid: no effect.
//  Word adds wrap mod 2^32, no carry between words.
// CONFIGURATION
//  CHACHA_CORE_FEEDFORWARD_EN defined: ADD computes work+init as above (standard ChaCha block).
//  Undefined: ADD copies work to out_state unchanged; init regs not built.
//   ADD cycle kept; latency/handshake identical either way.
// TESTING
//  1 Reset: rst=1 3 cycles mid-RUN -> in_ready=1, out_valid=0, out_state=0, busy=0 next cycle; new block then completes normally.
//  2 ROUNDS=10, FEEDFORWARD_EN, in = 61707865 3320646e 79622d32 6b206574, key 03020100..1f1e1d1c, 00000001 09000000 4a000000 00000000
//    -> out word0..3 = e4e7f110 15593bd1 1fdd0f50 c47120a3, word15 = 4e3c50a2; out_valid exactly 101 edges after accept.
//  3 Zero state, ROUNDS=4 -> out_state all zero at edge 41; both macro settings.
//  4 Macro undefined, vector of test 2 -> out_state[i] = expected[i] - in_state[i] mod 2^32 for all 16 words.
//  5 Backpressure: out_ready=0 for 20 cycles -> out_valid/out_state stable, in_ready=0, second in_valid ignored;
//    out_ready=1 -> IDLE next cycle, then second block accepted.
//  6 Back-to-back: in_valid and out_ready held 1, ROUNDS=4 -> accepts spaced exactly 43 cycles, results in order.

Source files
------------

// File: rtl/chacha_core.sv
// ChaCha block core: round scheduler around four pipelined quarter-round lanes, then feed-forward.
// Define CHACHA_CORE_FEEDFORWARD_EN to add the input state to the permuted state; otherwise the permuted state is emitted.

// One ChaCha quarter round split into four register stages.
// Latency 4 cycles while clk_en_i is high; no backpressure, the caller schedules around the fixed latency.
module chacha_qr4 (
   input  logic        clk,
   input  logic        clk_en_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic [31:0] c_i,
   input  logic [31:0] d_i,
   output logic [31:0] a_o,
   output logic [31:0] b_o,
   output logic [31:0] c_o,
   output logic [31:0] d_o
);
   // Packed as {d, c, b, a}: index 0 = a .. 3 = d.
   logic [3:0][31:0] st1_q, st1_d;
   logic [3:0][31:0] st2_q, st2_d;
   logic [3:0][31:0] st3_q, st3_d;
   logic [3:0][31:0] st4_q, st4_d;
   logic [31:0]      sum1, sum2, sum3, sum4;
   logic [31:0]      x1, x2, x3, x4;

   always_comb begin
      sum1     = a_i + b_i;
      x1       = d_i ^ sum1;
      st1_d[0] = sum1;
      st1_d[1] = b_i;
      st1_d[2] = c_i;
      st1_d[3] = {x1[15:0], x1[31:16]};

      sum2     = st1_q[2] + st1_q[3];
      x2       = st1_q[1] ^ sum2;
      st2_d[0] = st1_q[0];
      st2_d[1] = {x2[19:0], x2[31:20]};
      st2_d[2] = sum2;
      st2_d[3] = st1_q[3];

      sum3     = st2_q[0] + st2_q[1];
      x3       = st2_q[3] ^ sum3;
      st3_d[0] = sum3;
      st3_d[1] = st2_q[1];
      st3_d[2] = st2_q[2];
      st3_d[3] = {x3[23:0], x3[31:24]};

      sum4     = st3_q[2] + st3_q[3];
      x4       = st3_q[1] ^ sum4;
      st4_d[0] = st3_q[0];
      st4_d[1] = {x4[24:0], x4[31:25]};
      st4_d[2] = sum4;
      st4_d[3] = st3_q[3];
   end

   always_ff @(posedge clk) begin
      if (clk_en_i) begin
         st1_q <= st1_d;
         st2_q <= st2_d;
         st3_q <= st3_d;
         st4_q <= st4_d;
      end
   end

   assign a_o = st4_q[0];
   assign b_o = st4_q[1];
   assign c_o = st4_q[2];
   assign d_o = st4_q[3];
endmodule

// Runs 2*ROUNDS half-rounds of 5 cycles each on one block, then one ADD cycle.
// Latency: accept edge to out_valid = 10*ROUNDS+1 edges; one block in flight.
// Backpressure: out_state held in DONE until out_ready; in_ready only while IDLE.
module chacha_core #(
   parameter int ROUNDS = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [511:0] in_state,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [511:0] out_state,
   output logic         busy
);
   typedef enum logic [1:0] {IDLE, RUN, ADD, DONE} state_t;

   localparam logic [4:0] LAST_HALF = 5'(2 * ROUNDS - 1);

   state_t            state_q, state_d;
   logic [2:0]        phase_q, phase_d;
   logic [4:0]        half_q, half_d;
   logic [15:0][31:0] work_q, work_d;
   logic [511:0]      out_state_q, out_state_d;
`ifdef CHACHA_CORE_FEEDFORWARD_EN
   logic [15:0][31:0] init_q, init_d;
`endif
   logic [3:0][31:0]  qa_in, qb_in, qc_in, qd_in;
   logic [3:0][31:0]  qa_out, qb_out, qc_out, qd_out;

   // Word index of element j (a..d) in lane k; odd halves rotate the column by j for the diagonals.
   function automatic logic [3:0] lane_idx(input logic odd, input logic [1:0] k, input logic [1:0] j);
      logic [1:0] col;
      col = odd ? k + j : k;
      return {j, col};
   endfunction

   always_comb begin
      for (int k = 0; k < 4; k++) begin
         qa_in[k] = work_q[lane_idx(half_q[0], 2'(k), 2'd0)];
         qb_in[k] = work_q[lane_idx(half_q[0], 2'(k), 2'd1)];
         qc_in[k] = work_q[lane_idx(half_q[0], 2'(k), 2'd2)];
         qd_in[k] = work_q[lane_idx(half_q[0], 2'(k), 2'd3)];
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_lane
      chacha_qr4 u_qr (
         .clk      (clk),
         .clk_en_i (1'b1),
         .a_i      (qa_in[g]),
         .b_i      (qb_in[g]),
         .c_i      (qc_in[g]),
         .d_i      (qd_in[g]),
         .a_o      (qa_out[g]),
         .b_o      (qb_out[g]),
         .c_o      (qc_out[g]),
         .d_o      (qd_out[g])
      );
   end

   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      half_d      = half_q;
      work_d      = work_q;
      out_state_d = out_state_q;
`ifdef CHACHA_CORE_FEEDFORWARD_EN
      init_d      = init_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = RUN;
               phase_d = '0;
               half_d  = '0;
               work_d  = in_state;
`ifdef CHACHA_CORE_FEEDFORWARD_EN
               init_d  = in_state;
`endif
            end
         end
         RUN: begin
            // Phase 4: lane outputs now hold the words sampled at phase 0.
            if (phase_q == 3'd4) begin
               for (int k = 0; k < 4; k++) begin
                  work_d[lane_idx(half_q[0], 2'(k), 2'd0)] = qa_out[k];
                  work_d[lane_idx(half_q[0], 2'(k), 2'd1)] = qb_out[k];
                  work_d[lane_idx(half_q[0], 2'(k), 2'd2)] = qc_out[k];
                  work_d[lane_idx(half_q[0], 2'(k), 2'd3)] = qd_out[k];
               end
               phase_d = '0;
               if (half_q == LAST_HALF) begin
                  state_d = ADD;
                  half_d  = '0;
               end else begin
                  half_d = half_q + 5'd1;
               end
            end else begin
               phase_d = phase_q + 3'd1;
            end
         end
         ADD: begin
`ifdef CHACHA_CORE_FEEDFORWARD_EN
            for (int i = 0; i < 16; i++) begin
               out_state_d[32*i +: 32] = work_q[i] + init_q[i];
            end
`else
            out_state_d = work_q;
`endif
            state_d = DONE;
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         phase_q     <= '0;
         half_q      <= '0;
         out_state_q <= '0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         half_q      <= half_d;
         out_state_q <= out_state_d;
      end
      work_q <= work_d;
`ifdef CHACHA_CORE_FEEDFORWARD_EN
      init_q <= init_d;
`endif
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign out_state = out_state_q;
endmodule

// File: tb/tb_chacha_core.sv
// Scoreboard bench for chacha_core: ROUNDS=10 instance driven with the RFC 7539 block vector,
// ROUNDS=4 instance driven with the all-zero state.
`timescale 1ns/1ps
module tb_chacha_core;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         v10, rd10, ov10, ordy10, busy10;
   logic [511:0] is10, os10;
   logic         v4, rd4, ov4, ordy4, busy4;
   logic [511:0] is4, os4;

   chacha_core #(.ROUNDS(10)) u10 (
      .clk(clk), .rst(rst), .in_valid(v10), .in_ready(rd10), .in_state(is10),
      .out_valid(ov10), .out_ready(ordy10), .out_state(os10), .busy(busy10)
   );
   chacha_core #(.ROUNDS(4)) u4 (
      .clk(clk), .rst(rst), .in_valid(v4), .in_ready(rd4), .in_state(is4),
      .out_valid(ov4), .out_ready(ordy4), .out_state(os4), .busy(busy4)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [511:0] ZERO = '0;
   logic [511:0] rfc_in, rfc_fin, rfc_exp;
   logic [511:0] exp10_q[$], exp4_q[$];
   int           acc10_q[$], acc4_q[$], acc10_h[$], acc4_h[$];
   logic         p10 = 1'b0, p4 = 1'b0;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", name, act, req);
      end
   endtask

   // Monitor: logs accept edges, and on each rising out_valid pops and compares data and latency.
   always @(negedge clk) begin
      if (rst) begin
         p10 = 1'b0;
         p4  = 1'b0;
      end else begin
         if (v10 && rd10) begin acc10_q.push_back(cyc + 1); acc10_h.push_back(cyc + 1); end
         if (v4 && rd4) begin acc4_q.push_back(cyc + 1); acc4_h.push_back(cyc + 1); end
         if (ov10 && !p10) begin
            if (exp10_q.size() == 0 || acc10_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL u10_unexpected: out_valid rose with nothing outstanding, want no output");
            end else begin
               chk("u10_out_state", os10, exp10_q.pop_front());
               chk_int("u10_latency", cyc - acc10_q.pop_front(), 101);
            end
         end
         if (ov4 && !p4) begin
            if (exp4_q.size() == 0 || acc4_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL u4_unexpected: out_valid rose with nothing outstanding, want no output");
            end else begin
               chk("u4_out_state", os4, exp4_q.pop_front());
               chk_int("u4_latency", cyc - acc4_q.pop_front(), 41);
            end
         end
         p10 = ov10;
         p4  = ov4;
      end
   end

   task automatic wait_rdy(input bit big);
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (big ? rd10 : rd4) return;
      end
      checks++; errors++;
      $display("FAIL wait_rdy_%0d: in_ready stayed 0, want 1", big);
   endtask

   task automatic wait_out(input bit big);
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (big ? ov10 : ov4) return;
      end
      checks++; errors++;
      $display("FAIL wait_out_%0d: out_valid stayed 0, want 1", big);
   endtask

   task automatic send(input bit big, input logic [511:0] st, input logic [511:0] ex);
      if (big) begin exp10_q.push_back(ex); is10 = st; v10 = 1'b1; end
      else begin exp4_q.push_back(ex); is4 = st; v4 = 1'b1; end
      wait_rdy(big);
      @(posedge clk); #1;
      if (big) v10 = 1'b0; else v4 = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: still running at %0t, want finished", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base10, base4;
      rfc_in  = {32'h00000000, 32'h4a000000, 32'h09000000, 32'h00000001,
                 32'h1f1e1d1c, 32'h1b1a1918, 32'h17161514, 32'h13121110,
                 32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100,
                 32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
      rfc_fin = {32'h4e3c50a2, 32'he883d0cb, 32'hb94e16de, 32'hd19c12b5,
                 32'ha2028bd9, 32'h05d7c214, 32'h09aa9f07, 32'h466482d2,
                 32'h4e6cd4c3, 32'h9aaa2204, 32'h0368c033, 32'hc7f4d1c7,
                 32'hc47120a3, 32'h1fdd0f50, 32'h15593bd1, 32'he4e7f110};
`ifdef CHACHA_CORE_FEEDFORWARD_EN
      rfc_exp = rfc_fin;
`else
      for (int i = 0; i < 16; i++) rfc_exp[32*i +: 32] = rfc_fin[32*i +: 32] - rfc_in[32*i +: 32];
`endif
      rst = 1'b1; v10 = 1'b0; v4 = 1'b0; ordy10 = 1'b1; ordy4 = 1'b1; is10 = '0; is4 = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk_int("rst_in_ready10", int'(rd10), 1);
      chk_int("rst_out_valid10", int'(ov10), 0);
      chk_int("rst_busy10", int'(busy10), 0);
      chk("rst_out_state10", os10, ZERO);
      chk_int("rst_in_ready4", int'(rd4), 1);
      chk_int("rst_out_valid4", int'(ov4), 0);
      chk_int("rst_busy4", int'(busy4), 0);

      // RFC vector, ROUNDS=10
      send(1'b1, rfc_in, rfc_exp);
      wait_out(1'b1);
      @(posedge clk); #1;

      // Reset mid-RUN aborts the block; out_state nonzero beforehand
      send(1'b1, rfc_in, rfc_exp);
      repeat (30) @(posedge clk);
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      exp10_q.delete();
      acc10_q.delete();
      chk_int("midrst_in_ready", int'(rd10), 1);
      chk_int("midrst_out_valid", int'(ov10), 0);
      chk_int("midrst_busy", int'(busy10), 0);
      chk("midrst_out_state", os10, ZERO);
      send(1'b1, rfc_in, rfc_exp);
      wait_out(1'b1);
      @(posedge clk); #1;

      // Zero state, ROUNDS=4
      send(1'b0, ZERO, ZERO);
      wait_out(1'b0);
      @(posedge clk); #1;

      // Backpressure: hold output, ignore a second request while busy
      ordy10 = 1'b0;
      send(1'b1, rfc_in, rfc_exp);
      wait_out(1'b1);
      @(posedge clk); #1;
      exp10_q.push_back(ZERO);
      is10 = ZERO;
      v10  = 1'b1;
      for (int n = 0; n < 20; n++) begin
         @(posedge clk); #1;
         chk_int("bp_out_valid", int'(ov10), 1);
         chk_int("bp_in_ready", int'(rd10), 0);
         chk("bp_out_state", os10, rfc_exp);
      end
      ordy10 = 1'b1;
      @(posedge clk); #1;
      chk_int("bp_release_out_valid", int'(ov10), 0);
      chk_int("bp_release_in_ready", int'(rd10), 1);
      @(posedge clk); #1;
      v10 = 1'b0;
      chk_int("bp_second_accepted", int'(busy10), 1);
      wait_out(1'b1);
      @(posedge clk); #1;

      // Back-to-back: in_valid and out_ready held high
      base10 = acc10_h.size();
      v10 = 1'b1;
      for (int b = 0; b < 3; b++) begin
         is10 = (b == 1) ? ZERO : rfc_in;
         exp10_q.push_back((b == 1) ? ZERO : rfc_exp);
         wait_rdy(1'b1);
         @(posedge clk); #1;
      end
      v10 = 1'b0;
      base4 = acc4_h.size();
      v4 = 1'b1;
      is4 = ZERO;
      for (int b = 0; b < 3; b++) begin
         exp4_q.push_back(ZERO);
         wait_rdy(1'b0);
         @(posedge clk); #1;
      end
      v4 = 1'b0;

      for (int n = 0; n < 400 && (exp10_q.size() != 0 || exp4_q.size() != 0); n++) @(negedge clk);
      chk_int("drain10", exp10_q.size(), 0);
      chk_int("drain4", exp4_q.size(), 0);
      for (int i = 1; i < 3; i++) begin
         chk_int("b2b10_spacing", (acc10_h.size() > base10 + i) ? acc10_h[base10 + i] - acc10_h[base10 + i - 1] : -1, 103);
         chk_int("b2b4_spacing", (acc4_h.size() > base4 + i) ? acc4_h[base4 + i] - acc4_h[base4 + i - 1] : -1, 43);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
